core_load_unit: RTL

- Load-side counterpart of the store-path byte-lane logic.
- Accepts load requests from the memory stage and issues word-aligned reads on the data bus.
- Tracks up to OUTSTANDING loads in order; extracts the byte, half or word from the returned lane and sign- or zero-extends it per funct3.
- Delivers results to writeback over a valid/ready handshake. Sits between the execute/memory stage and the register-file writeback mux.

---
 rtl/core_lsu_pkg.sv | 31 +++
 rtl/core_load_align.sv | 20 ++
 rtl/core_load_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/core_lsu_pkg.sv
// core_lsu_pkg: shared load/store types, funct3 codes and access checks
package core_lsu_pkg;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  typedef enum logic [1:0] {
    FLT_OK       = 2'b00,
    FLT_MISALIGN = 2'b01,
    FLT_BUS      = 2'b10,
    FLT_ILLEGAL  = 2'b11
  } fault_e;
  typedef struct packed {
    logic [2:0]  funct3;
    logic [1:0]  alow;
    logic [4:0]  rd;
    logic        filled;
    logic [31:0] data;
    fault_e      fault;
  } ld_entry_t;
  function automatic logic is_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) | (f3[2:1] == 2'b11);
  endfunction
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == 2'b01) & a[0]) | ((f3[1:0] == 2'b10) & (a != 2'b00));
  endfunction
  function automatic logic [3:0] lane_sel(input logic [2:0] f3, input logic [1:0] a);
    return f3[1] ? 4'b1111 : f3[0] ? (a[1] ? 4'b1100 : 4'b0011) : 4'b0001 << a;
  endfunction
endpackage

// File: rtl/core_load_align.sv
// core_load_align: selects the byte/half/word lane of a read word and extends it
module core_load_align
  import core_lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_low,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);
  logic [7:0]  b;
  logic [15:0] h;
  logic        sx;
  always_comb begin
    b = i_rdata[{i_addr_low, 3'b000} +: 8];
    h = i_rdata[{i_addr_low[1], 4'b0000} +: 16];
    sx = ~i_funct3[2];
    o_data = i_funct3[1] ? i_rdata :
             i_funct3[0] ? {{16{sx & h[15]}}, h} : {{24{sx & b[7]}}, b};
  end
endmodule

// File: rtl/core_load_unit.sv
// core_load_unit: in-order load tracker issuing word reads and returning extended results
module core_load_unit
  import core_lsu_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [4:0]        i_rd,
  output logic              o_bus_req,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [3:0]        o_bus_sel,
  input  logic              i_bus_ack,
  input  logic              i_bus_rvalid,
  input  logic [31:0]       i_bus_rdata,
  input  logic              i_bus_err,
  output logic              o_wb_valid,
  input  logic              i_wb_ready,
  output logic [31:0]       o_wb_data,
  output logic [4:0]        o_wb_rd,
  output logic [1:0]        o_wb_fault,
  output logic              o_busy
);
  localparam int PW = OUTSTANDING > 1 ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  ld_entry_t         ent_q [OUTSTANDING];
  ld_entry_t         ent_d [OUTSTANDING];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d, fill_idx;
  logic [CW-1:0]     count_q, count_d;
  logic              bus_req_q, bus_req_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]        bus_sel_q, bus_sel_d;
  logic              wb_valid_q, wb_valid_d;
  logic [31:0]       wb_data_q, wb_data_d, aligned;
  logic [4:0]        wb_rd_q, wb_rd_d;
  fault_e            wb_fault_q, wb_fault_d, req_fault;
  logic              push, pop, found, fill;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction
  core_load_align u_align (
    .i_funct3  (ent_q[fill_idx].funct3),
    .i_addr_low(ent_q[fill_idx].alow),
    .i_rdata   (i_bus_rdata),
    .o_data    (aligned)
  );
  assign o_req_ready = i_reset_n & (count_q < CW'(OUTSTANDING)) & !bus_req_q;
  assign o_bus_req   = bus_req_q;
  assign o_bus_addr  = bus_addr_q;
  assign o_bus_sel   = bus_sel_q;
  assign o_wb_valid  = wb_valid_q;
  assign o_wb_data   = wb_data_q;
  assign o_wb_rd     = wb_rd_q;
  assign o_wb_fault  = wb_fault_q;
  assign o_busy      = (count_q != '0) | bus_req_q;
  always_comb begin
    push = i_req_valid & o_req_ready;
    req_fault = is_illegal(i_funct3) ? FLT_ILLEGAL :
                is_misaligned(i_funct3, i_addr[1:0]) ? FLT_MISALIGN : FLT_OK;
    found = 1'b0;
    fill_idx = head_q;
    for (int k = 0; k < OUTSTANDING; k++) begin
      if (!found && k < int'(count_q) && !ent_q[(int'(head_q) + k) % OUTSTANDING].filled) begin
        found = 1'b1;
        fill_idx = PW'((int'(head_q) + k) % OUTSTANDING);
      end
    end
    fill = found & i_bus_rvalid;
    ent_d = ent_q;
    if (fill) begin
      ent_d[fill_idx].filled = 1'b1;
      ent_d[fill_idx].data = i_bus_err ? '0 : aligned;
      ent_d[fill_idx].fault = i_bus_err ? FLT_BUS : FLT_OK;
    end
    if (push)
      ent_d[tail_q] = '{funct3: i_funct3, alow: i_addr[1:0], rd: i_rd,
                        filled: req_fault != FLT_OK, data: '0, fault: req_fault};
    // pop sees this cycle's push and fill, giving the one-cycle result latency
    pop = ((count_q != '0) | push) & ent_d[head_q].filled & (!wb_valid_q | i_wb_ready);
    count_d = count_q + CW'(push) - CW'(pop);
    head_d = pop ? nxt(head_q) : head_q;
    tail_d = push ? nxt(tail_q) : tail_q;
    bus_req_d = bus_req_q ? !i_bus_ack : push & (req_fault == FLT_OK);
    bus_addr_d = push ? {i_addr[ADDR_W-1:2], 2'b00} : bus_addr_q;
    bus_sel_d = push ? lane_sel(i_funct3, i_addr[1:0]) : bus_sel_q;
    wb_valid_d = pop | (wb_valid_q & !i_wb_ready);
    wb_data_d = pop ? ent_d[head_q].data : wb_data_q;
    wb_rd_d = pop ? ent_d[head_q].rd : wb_rd_q;
    wb_fault_d = pop ? ent_d[head_q].fault : wb_fault_q;
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < OUTSTANDING; i++) ent_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      bus_req_q <= 1'b0;
      bus_addr_q <= '0;
      bus_sel_q <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q <= '0;
      wb_rd_q <= '0;
      wb_fault_q <= FLT_OK;
    end else begin
      ent_q <= ent_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      bus_req_q <= bus_req_d;
      bus_addr_q <= bus_addr_d;
      bus_sel_q <= bus_sel_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q <= wb_data_d;
      wb_rd_q <= wb_rd_d;
      wb_fault_q <= wb_fault_d;
    end
  end
endmodule
